// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller sequencing one shared full-add slice LSB-first
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_next;
  logic [CNT_W-1:0] cnt;
  logic carry, p, g0, s, g1, c, last;
  half_adder ha0 (.a(a_sh[0]), .b(b_sh[0]), .s(p), .c(g0));
  half_adder ha1 (.a(p), .b(carry), .s(s), .c(g1));
  assign c = g0 | g1;
  assign r_next = WIDTH'({s, r_sh} >> 1);
  assign last = cnt == CNT_W'(WIDTH - 1);
  // Controller: accept in IDLE/DONE, step the slice in RUN, publish result on the last bit
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      S <= '0;
      Cout <= 1'b0;
      a_sh <= '0;
      b_sh <= '0;
      r_sh <= '0;
      carry <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      r_sh <= r_next;
      carry <= c;
      cnt <= cnt + CNT_W'(1);
      if (last) begin
        S <= r_next;
        Cout <= c;
        busy <= 1'b0;
        done <= 1'b1;
        state <= DONE;
      end
    end else begin
      done <= 1'b0;
      busy <= start;
      state <= start ? RUN : IDLE;
      if (start) begin
        a_sh <= A;
        b_sh <= B;
        carry <= Cin;
        cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and random checks of serial_add_ctrl against plain arithmetic
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic start1 = 1'b0, cin1 = 1'b0, busy1, done1, cout1;
  logic [0:0] a1 = '0, b1 = '0, s1;
  int checks = 0;
  int errors = 0;
  logic [7:0] held_s = '0;
  logic held_c = 1'b0;

  serial_add_ctrl #(.WIDTH(8), .CNT_W(6)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Cin(cin8),
    .busy(busy8), .done(done8), .S(s8), .Cout(cout8)
  );
  serial_add_ctrl #(.WIDTH(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .Cin(cin1),
    .busy(busy1), .done(done1), .S(s1), .Cout(cout1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start8_op(input logic [7:0] a, input logic [7:0] b, input logic c);
    a8 = a;
    b8 = b;
    cin8 = c;
    start8 = 1'b1;
    tick;
    start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    cin8 = 1'($urandom);
  endtask

  task automatic finish8(input logic [7:0] a, input logic [7:0] b, input logic c, input string tag, input int ign_at);
    logic [8:0] sum;
    sum = 9'(a) + 9'(b) + 9'(c);
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_run_busy"}, 32'(busy8), 32'd1);
      chk({tag, "_run_done"}, 32'(done8), 32'd0);
      chk({tag, "_run_S_held"}, 32'(s8), 32'(held_s));
      chk({tag, "_run_Cout_held"}, 32'(cout8), 32'(held_c));
      if (i == ign_at) begin
        start8 = 1'b1;
        a8 = 8'h55;
        b8 = 8'($urandom);
      end
      tick;
      start8 = 1'b0;
    end
    chk({tag, "_done"}, 32'(done8), 32'd1);
    chk({tag, "_done_busy"}, 32'(busy8), 32'd0);
    chk({tag, "_S"}, 32'(s8), 32'(sum[7:0]));
    chk({tag, "_Cout"}, 32'(cout8), 32'(sum[8]));
    held_s = sum[7:0];
    held_c = sum[8];
  endtask

  task automatic post8(input string tag);
    tick;
    chk({tag, "_post_done"}, 32'(done8), 32'd0);
    chk({tag, "_post_busy"}, 32'(busy8), 32'd0);
    chk({tag, "_post_S"}, 32'(s8), 32'(held_s));
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic rc;
    logic [1:0] sum1;
    tick;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("rst_busy8", 32'(busy8), 32'd0);
      chk("rst_done8", 32'(done8), 32'd0);
      chk("rst_S8", 32'(s8), 32'd0);
      chk("rst_Cout8", 32'(cout8), 32'd0);
      chk("rst_dut1", 32'({busy1, done1, s1, cout1}), 32'd0);
      tick;
    end

    start8_op(8'h0F, 8'h01, 1'b0);
    finish8(8'h0F, 8'h01, 1'b0, "basic", -1);
    post8("basic");

    start8_op(8'hFF, 8'h00, 1'b1);
    finish8(8'hFF, 8'h00, 1'b1, "ripple0", -1);
    post8("ripple0");
    start8_op(8'hFF, 8'hFF, 1'b1);
    finish8(8'hFF, 8'hFF, 1'b1, "ripple1", -1);
    post8("ripple1");

    start8_op(8'h0F, 8'h01, 1'b0);
    finish8(8'h0F, 8'h01, 1'b0, "ignored", 2);
    a8 = 8'h02;
    b8 = 8'h03;
    cin8 = 1'b0;
    start8 = 1'b1;
    tick;
    start8 = 1'b0;
    a8 = 8'($urandom);
    finish8(8'h02, 8'h03, 1'b0, "b2b", -1);
    post8("b2b");

    start8_op(8'hAA, 8'h55, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_busy", 32'(busy8), 32'd1);
      tick;
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    held_s = '0;
    held_c = 1'b0;
    chk("abort_S", 32'(s8), 32'd0);
    chk("abort_Cout", 32'(cout8), 32'd0);
    for (int i = 0; i < 10; i++) begin
      chk("abort_busy_low", 32'(busy8), 32'd0);
      chk("abort_no_done", 32'(done8), 32'd0);
      tick;
    end
    start8_op(8'hAA, 8'h55, 1'b0);
    finish8(8'hAA, 8'h55, 1'b0, "fresh", -1);
    post8("fresh");

    for (int n = 0; n < 20; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      start8_op(ra, rb, rc);
      finish8(ra, rb, rc, "rand", -1);
      post8("rand");
    end

    for (int v = 0; v < 8; v++) begin
      a1 = 1'(v);
      b1 = 1'(v >> 1);
      cin1 = 1'(v >> 2);
      sum1 = 2'(a1) + 2'(b1) + 2'(cin1);
      start1 = 1'b1;
      tick;
      start1 = 1'b0;
      a1 = ~a1;
      chk("w1_busy", 32'(busy1), 32'd1);
      chk("w1_run_done", 32'(done1), 32'd0);
      tick;
      chk("w1_done", 32'(done1), 32'd1);
      chk("w1_done_busy", 32'(busy1), 32'd0);
      chk("w1_sum", 32'({cout1, s1}), 32'(sum1));
      tick;
      chk("w1_post_done", 32'(done1), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller: accepts two WIDTH-bit operands plus carry-in on a start strobe.
- Steps one shared 1-bit full-add slice (built from two half adders) LSB-first over WIDTH clock cycles.
- Presents the registered sum and carry-out with a one-cycle done pulse.
- Sits between a requesting unit and the half-adder datapath, sequencing the shared slice so no WIDTH-bit ripple adder is needed.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 1 to 32.
- CNT_W, 6, bit counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request strobe, sampled only when idle or in DONE
- A  input  WIDTH  operand A, captured on accepted start
- B  input  WIDTH  operand B, captured on accepted start
- Cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while an addition is in progress (RUN state)
- done  output  1  one-cycle pulse, result valid
- S  output  WIDTH  registered sum, held until next completion
- Cout  output  1  registered carry-out, held until next completion

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, on port rst.
- Reset (rst=1 at a rising edge): state=IDLE, busy=0, done=0, S=0, Cout=0, internal operand shifters/counter/carry=0.
  - Reset overrides every other input.
  - Reset mid-RUN abandons the operation; no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> capture A, B into shift registers, carry<=Cin, count<=0, go RUN.
  - Otherwise stay in IDLE.
- RUN, each edge:
  - Slice computes s = a0^b0^carry and c = a0&b0 | carry&(a0^b0) via HA->HA->OR.
  - s shifts into the result shifter from the MSB end; operand shifters shift right; carry<=c; count<=count+1.
  - When count==WIDTH-1 at the edge: load S from the completed shifter, Cout<=c, go DONE.
- DONE (exactly one cycle):
  - done=1, busy=0.
  - start=1 in DONE is accepted (back-to-back): capture new operands and go RUN.
  - Otherwise go IDLE.
- Ignored start: start while in RUN has no effect; operands and carry are not disturbed.
- busy: high in exactly the WIDTH cycles of RUN, low in IDLE and DONE.
- Latency: start sampled at edge k -> done high in the cycle following edge k+WIDTH. Throughput is one addition per WIDTH+1 cycles.
- Output stability:
  - S and Cout change only on the transition into DONE (or on reset).
  - Partial sums are never visible on S during RUN.
- Arithmetic: {Cout,S} = A + B + Cin, unsigned, modulo 2^(WIDTH+1); no overflow flag.
- WIDTH=1: RUN lasts one cycle; done is high in the cycle after edge k+1.
- Operand inputs may change freely after the accepting edge; only captured values are used.

Test Plan:
1. Reset then idle: assert rst 2 cycles, start=0 for 10 cycles -> busy=0, done=0, S=0, Cout=0 throughout.
2. WIDTH=8, A=8'h0F, B=8'h01, Cin=0, start pulsed at edge k -> busy high 8 cycles, done=1 in the cycle following edge k+8, S=8'h10, Cout=0.
3. Full carry ripple: A=8'hFF, B=8'h00, Cin=1 -> S=8'h00, Cout=1. Then A=8'hFF, B=8'hFF, Cin=1 -> S=8'hFF, Cout=1.
4. Start during RUN: second start with A=8'h55 at edge k+3 -> ignored; first result S=8'h10 delivered unchanged, one done pulse only. Back-to-back start asserted during the DONE cycle with A=8'h02, B=8'h03 -> busy rises the next cycle, second done 9 cycles after the first, S=8'h05, Cout=0.
5. Reset mid-operation: rst=1 at edge k+4 of an 8'hAA+8'h55 add -> state IDLE, S=0, Cout=0, no done pulse. A fresh add 8'hAA+8'h55+0 then yields S=8'hFF, Cout=0.
6. WIDTH=1 instance: exhaustive A, B, Cin in {0,1} -> {Cout,S} equals the 2-bit sum each time; done one cycle after the RUN cycle.
